// File: rtl/iob_soc_opencryptolinux_boot_copy_pkg.sv
// Shared types and helpers for the boot-ROM-to-SRAM copy engine.
// FSM state encoding plus the word-size byte helper.
package iob_soc_opencryptolinux_boot_copy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    function automatic int unsigned word_bytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/iob_soc_opencryptolinux_boot_copy_ctr.sv
// Word counter for the copy engine: clear on start, step per accepted write.
// last_o flags the final word so the FSM knows when to stop; never wraps.
module iob_soc_opencryptolinux_boot_copy_ctr #(
    parameter int unsigned WORDS = 1024
) (
    input  logic                         clk_i,
    input  logic                         cke_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         en_i,
    output logic [$clog2(WORDS+1)-1:0]   cnt_o,
    output logic                         last_o
);

    localparam int unsigned CNT_W = $clog2(WORDS + 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (cke_i) begin
            if (clear_i) begin
                cnt_o <= '0;
            end else if (en_i) begin
                cnt_o <= cnt_o + CNT_W'(1);
            end
        end
    end

    assign last_o = (cnt_o == CNT_W'(WORDS - 1));

endmodule

// File: rtl/iob_soc_opencryptolinux_boot_copy.sv
// Copies WORDS boot-ROM words into SRAM over IOb after a boot reset pulse, holding the CPU in reset meanwhile.
// Optional running checksum of written words: define IOB_SOC_OPENCRYPTOLINUX_BOOT_COPY_CSUM_EN.
module iob_soc_opencryptolinux_boot_copy #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       ROM_ADDR_W = 10,
    parameter int unsigned       WORDS      = 1024,
    parameter logic [ADDR_W-1:0] SRAM_BASE  = '0
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    input  logic                  boot_i,
    input  logic                  cpu_reset_i,
    output logic                  cpu_reset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rom_en_o,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0]     rom_rdata_i,
    output logic                  iob_valid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i
`ifdef IOB_SOC_OPENCRYPTOLINUX_BOOT_COPY_CSUM_EN
    ,
    output logic [DATA_W-1:0]     csum_o
`endif
);

    import iob_soc_opencryptolinux_boot_copy_pkg::*;

    localparam int unsigned BYTES = word_bytes(DATA_W);
    localparam int unsigned CNT_W = $clog2(WORDS + 1);

    state_t           state;
    logic             cpu_reset_q;
    logic             start;
    logic             advance;
    logic             last;
    logic [CNT_W-1:0] cnt;

    // Falling edge of the CPU reset pulse with boot requested, only from idle.
    assign start       = boot_i & cpu_reset_q & ~cpu_reset_i & (state == IDLE);
    assign advance     = (state == WRITE) & iob_ready_i;
    assign cpu_reset_o = cpu_reset_i | start | busy_o;
    assign iob_wstrb_o = '1;

    iob_soc_opencryptolinux_boot_copy_ctr #(
        .WORDS(WORDS)
    ) u_ctr (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .rst_i  (rst_i),
        .clear_i(start),
        .en_i   (advance & ~last),
        .cnt_o  (cnt),
        .last_o (last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cpu_reset_q <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            rom_en_o    <= 1'b0;
            rom_addr_o  <= '0;
            iob_valid_o <= 1'b0;
            iob_addr_o  <= '0;
            iob_wdata_o <= '0;
        end else if (cke_i) begin
            cpu_reset_q <= cpu_reset_i;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= READ;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        rom_en_o   <= 1'b1;
                        rom_addr_o <= '0;
                    end
                end
                READ: begin
                    state    <= WAIT;
                    rom_en_o <= 1'b0;
                end
                WAIT: begin
                    state       <= WRITE;
                    iob_wdata_o <= rom_rdata_i;
                    iob_valid_o <= 1'b1;
                    iob_addr_o  <= SRAM_BASE + ADDR_W'(cnt) * ADDR_W'(BYTES);
                end
                WRITE: begin
                    // Request fields are held until the SRAM accepts.
                    if (iob_ready_i) begin
                        iob_valid_o <= 1'b0;
                        if (last) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            state      <= READ;
                            rom_en_o   <= 1'b1;
                            rom_addr_o <= ROM_ADDR_W'(cnt + CNT_W'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IOB_SOC_OPENCRYPTOLINUX_BOOT_COPY_CSUM_EN
    // Running sum of words the SRAM has accepted during the current copy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csum_o <= '0;
        end else if (cke_i) begin
            if (start) begin
                csum_o <= '0;
            end else if (advance) begin
                csum_o <= csum_o + iob_wdata_o;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iob_soc_opencryptolinux_boot_copy.sv
// Scoreboard bench for the boot copy engine: stimulus pushes expected SRAM writes,
// a negedge monitor models ROM/SRAM, drives ready and checks every accepted write.
`timescale 1ns/1ps
module tb_iob_soc_opencryptolinux_boot_copy;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned ROM_ADDR_W = 10;
    localparam int unsigned WORDS      = 4;
    localparam logic [ADDR_W-1:0] BASE = 32'h0000_0100;

    logic                  clk = 1'b0;
    logic                  cke, rst, boot, cpu_rst_in, cpu_rst_out;
    logic                  busy, done, rom_en, iob_valid, iob_ready;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0]     rom_rdata, iob_wdata;
    logic [ADDR_W-1:0]     iob_addr;
    logic [DATA_W/8-1:0]   iob_wstrb;
`ifdef IOB_SOC_OPENCRYPTOLINUX_BOOT_COPY_CSUM_EN
    logic [DATA_W-1:0]     csum;
`endif

    always #5 clk = ~clk;

    iob_soc_opencryptolinux_boot_copy #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROM_ADDR_W(ROM_ADDR_W),
        .WORDS(WORDS), .SRAM_BASE(BASE)
    ) dut (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .boot_i(boot),
        .cpu_reset_i(cpu_rst_in), .cpu_reset_o(cpu_rst_out),
        .busy_o(busy), .done_o(done),
        .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata),
        .iob_valid_o(iob_valid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
        .iob_wstrb_o(iob_wstrb), .iob_ready_i(iob_ready)
`ifdef IOB_SOC_OPENCRYPTOLINUX_BOOT_COPY_CSUM_EN
        , .csum_o(csum)
`endif
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] rom_mem [WORDS];
    int                vectors = 0, miscompares = 0;
    int                writes = 0, rom_reads = 0, stalls = 0;
    int                mode = 0, stall_left = 0;
    logic              done_exp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ROM, SRAM responder and write checker; sampled mid-cycle, away from posedge.
    logic              pend = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [ROM_ADDR_W-1:0] pend_addr = '0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;
    initial begin
        rom_rdata = '0;
        iob_ready = 1'b0;
    end
    always @(negedge clk) begin
        logic r;
        exp_t e;
        rom_rdata = (pend && int'(pend_addr) < int'(WORDS)) ? rom_mem[int'(pend_addr)] : DATA_W'($urandom);
        pend      = rom_en;
        pend_addr = rom_addr;
        if (rom_en) rom_reads++;
        case (mode)
            0: r = 1'b1;
            1: r = 1'($urandom_range(0, 1));
            2: if (iob_valid && sb_q.size() == WORDS - 2 && stall_left > 0) begin
                   r = 1'b0;
                   stall_left--;
               end else r = 1'b1;
            default: r = (sb_q.size() == WORDS);
        endcase
        if (prev_valid && !prev_ready && !rst) begin
            chk("stall_valid", 64'(iob_valid), 64'd1);
            chk("stall_addr", 64'(iob_addr), 64'(prev_addr));
            chk("stall_wdata", 64'(iob_wdata), 64'(prev_data));
        end
        iob_ready = r;
        if (iob_valid) begin
            chk("wstrb", 64'(iob_wstrb), 64'hF);
            if (!r) stalls++;
        end
        if (iob_valid && r) begin
            writes++;
            if (sb_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
            else begin
                e = sb_q.pop_front();
                chk("wr_addr", 64'(iob_addr), 64'(e.a));
                chk("wr_data", 64'(iob_wdata), 64'(e.d));
            end
        end
        prev_valid = iob_valid;
        prev_ready = r;
        prev_addr  = iob_addr;
        prev_data  = iob_wdata;
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // One reset pulse; model: a boot copy writes ROM[i] to BASE+4i and holds reset 3*WORDS+stalls cycles.
    task automatic run_copy(input bit do_boot, input int m, input bit repulse);
        int n, st0, w0, r0;
        bit fell;
        logic [DATA_W-1:0] sum;
        mode = m;
        stall_left = 5;
        boot = do_boot;
        cpu_rst_in = 1'b1;
        step();
        step();
        st0 = stalls; w0 = writes; r0 = rom_reads;
        sum = '0;
        if (do_boot) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                sb_q.push_back('{a: BASE + ADDR_W'(4 * i), d: rom_mem[i]});
                sum += rom_mem[i];
            end
        end
        cpu_rst_in = 1'b0;
        #1;
        chk("rst_out_at_edge", 64'(cpu_rst_out), 64'(do_boot));
        n = 0;
        fell = 0;
        for (int k = 1; k < 300 && !fell; k++) begin
            step();
            if (repulse && k == 4) cpu_rst_in = 1'b1;
            if (repulse && k == 6) cpu_rst_in = 1'b0;
            #1;
            if (do_boot && k == 1) chk("done_cleared", 64'(done), 64'd0);
            if (cpu_rst_out) n++;
            else fell = 1;
        end
        if (!fell) chk("rst_release_timeout", 64'd0, 64'd1);
        chk("rst_out_cycles", 64'(n), do_boot ? 64'(3 * WORDS + (stalls - st0)) : 64'd0);
        step();
        step();
        if (do_boot) done_exp = 1'b1;
        chk("writes", 64'(writes - w0), do_boot ? 64'(WORDS) : 64'd0);
        chk("rom_reads", 64'(rom_reads - r0), do_boot ? 64'(WORDS) : 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("done", 64'(done), 64'(done_exp));
        chk("busy_after", 64'(busy), 64'd0);
`ifdef IOB_SOC_OPENCRYPTOLINUX_BOOT_COPY_CSUM_EN
        if (do_boot) chk("csum", 64'(csum), 64'(sum));
`endif
        sb_q.delete();
    endtask

    // rst_i while word 1 is stalled in WRITE: everything returns to idle, no more requests.
    task automatic run_abort();
        int w0, r0;
        mode = 3;
        boot = 1'b1;
        cpu_rst_in = 1'b1;
        step();
        step();
        for (int i = 0; i < int'(WORDS); i++)
            sb_q.push_back('{a: BASE + ADDR_W'(4 * i), d: rom_mem[i]});
        cpu_rst_in = 1'b0;
        for (int k = 0; k < 100 && !(iob_valid && sb_q.size() == WORDS - 1); k++) step();
        chk("abort_reached_word1", 64'(iob_valid && sb_q.size() == WORDS - 1), 64'd1);
        rst = 1'b1;
        cpu_rst_in = 1'b1;
        step();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_valid", 64'(iob_valid), 64'd0);
        rst = 1'b0;
        sb_q.delete();
        done_exp = 1'b0;
        w0 = writes; r0 = rom_reads;
        repeat (8) step();
        chk("abort_no_writes", 64'(writes - w0), 64'd0);
        chk("abort_no_reads", 64'(rom_reads - r0), 64'd0);
        chk("abort_done_stays", 64'(done), 64'd0);
    endtask

    initial begin
        cke = 1'b1; rst = 1'b1; boot = 1'b0; cpu_rst_in = 1'b1;
        for (int i = 0; i < int'(WORDS); i++) rom_mem[i] = 32'hA0 + 32'(i);
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rom_en", 64'(rom_en), 64'd0);
        chk("rst_valid", 64'(iob_valid), 64'd0);
        chk("rst_wdata", 64'(iob_wdata), 64'd0);
        chk("rst_cpu_reset", 64'(cpu_rst_out), 64'd1);
`ifdef IOB_SOC_OPENCRYPTOLINUX_BOOT_COPY_CSUM_EN
        chk("rst_csum", 64'(csum), 64'd0);
`endif
        run_copy(1'b0, 0, 1'b0);
        run_copy(1'b1, 0, 1'b0);
        run_copy(1'b1, 2, 1'b0);
        run_abort();
        run_copy(1'b1, 0, 1'b1);
        rom_mem[0] = 32'hFFFF_FFFF; rom_mem[1] = 32'd1; rom_mem[2] = 32'd2; rom_mem[3] = 32'd3;
        run_copy(1'b1, 0, 1'b0);
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < int'(WORDS); i++) rom_mem[i] = $urandom;
            run_copy($urandom_range(0, 3) != 0, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
